// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 receive path.
// FSM state encoding, parity modes and the FIFO entry layout.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int PARITY_ODD  = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_NONE = 2;

  localparam int DATA_MAX = 9;

  typedef struct packed {
    logic [DATA_MAX-1:0] data;
    logic                parity_err;
    logic                frame_err;
  } entry_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchroniser, stability filter and fall strobe for one raw line.
// The filtered level follows the input only after FILTER_LEN equal samples.
module ps2_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic sync,
  output logic filt,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN) + 1;
  localparam logic [CW-1:0] CLAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sr;
  logic [CW-1:0]          cnt;

  assign sync = sr[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '1;
      filt <= 1'b1;
      cnt  <= '0;
      fall <= 1'b0;
    end else begin
      sr   <= {sr[SYNC_STAGES-2:0], raw};
      fall <= 1'b0;
      if (sync == filt) begin
        cnt <= '0;
      end else if (cnt == CLAST) begin
        // old level high means this flip is a falling edge
        filt <= sync;
        fall <= filt;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with error flags, timeout recovery
// and a small FIFO presented as a valid/ready stream.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = 0,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int DEPTH          = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PS2_clk,
  input  logic                 PS2_dat,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_parity_err,
  output logic                 out_frame_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow,
  output logic                 timeout,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam bit HAS_PAR = (PARITY_MODE != PARITY_NONE);
  localparam logic ODD = (PARITY_MODE == PARITY_ODD);

  logic                   c_sync;
  logic                   c_filt;
  logic                   fall;
  logic [SYNC_STAGES-1:0] dsr;
  logic                   dat;

  ps2_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filt (
    .clk (clk),
    .rst (rst),
    .raw (PS2_clk),
    .sync(c_sync),
    .filt(c_filt),
    .fall(fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dsr <= '1;
    else     dsr <= {dsr[SYNC_STAGES-2:0], PS2_dat};
  end

  assign dat = dsr[SYNC_STAGES-1];

  state_t                 state;
  logic [BW-1:0]          bcnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_err;
  logic [TW-1:0]          tcnt;
  logic                   push_q;
  entry_t                 ent_q;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bcnt    <= '0;
      shreg   <= '0;
      par_err <= 1'b0;
      tcnt    <= '0;
      timeout <= 1'b0;
      push_q  <= 1'b0;
      ent_q   <= '0;
    end else begin
      timeout <= 1'b0;
      push_q  <= 1'b0;
      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + 1'b1;
      if (state != IDLE && !fall && tcnt == TLAST) begin
        state   <= IDLE;
        timeout <= 1'b1;
      end else if (fall) begin
        unique case (state)
          IDLE: begin
            if (!dat) begin
              state   <= DATA;
              bcnt    <= '0;
              par_err <= 1'b0;
            end
          end
          DATA: begin
            shreg <= {dat, shreg[DATA_BITS-1:1]};
            bcnt  <= bcnt + 1'b1;
            if (bcnt == BLAST) state <= HAS_PAR ? PARITY : STOP;
          end
          PARITY: begin
            par_err <= ((^shreg) ^ dat) != ODD;
            state   <= STOP;
          end
          STOP: begin
            push_q           <= 1'b1;
            ent_q.data       <= DATA_MAX'(shreg);
            ent_q.parity_err <= par_err;
            ent_q.frame_err  <= !dat;
            state            <= IDLE;
          end
        endcase
      end
    end
  end

  // FIFO: extra pointer MSB separates full from empty
  entry_t          mem [DEPTH];
  logic [AW:0]     wp;
  logic [AW:0]     rp;
  logic            full;
  logic            pop;
  logic            do_push;
  entry_t          head;
  logic            unused_head;

  assign out_valid = (wp != rp);
  assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop       = out_valid && out_ready;
  assign do_push   = push_q && (!full || pop);
  assign head      = mem[rp[AW-1:0]];
  assign unused_head = ^head.data;

  assign out_data       = out_valid ? head.data[DATA_BITS-1:0] : '0;
  assign out_parity_err = out_valid && head.parity_err;
  assign out_frame_err  = out_valid && head.frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      if (push_q && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= ent_q;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver. Both PS/2 lines are oversampled in the system clock domain; the line clock is glitch-filtered; frames are deframed with configurable data width and parity mode. Completed frames and their error flags are buffered in a FIFO and presented on a valid/ready stream. This replaces the single-register, edge-clocked receiver for keyboard/mouse front ends that need buffering, timeout recovery and error reporting.

Parameters:
DATA_BITS, 8, data bits per frame, sent LSB first (range 5..9)
PARITY_MODE, 0, 0 = odd parity, 1 = even parity, 2 = no parity bit
SYNC_STAGES, 2, synchroniser flops on PS2_clk and PS2_dat (minimum 2)
FILTER_LEN, 4, clk cycles PS2_clk must stay stable before its filtered level changes
TIMEOUT_CYCLES, 5000, clk cycles allowed between falling edges inside a frame
DEPTH, 4, FIFO entries (power of 2, minimum 2)

Ports:
clk  in  1  system clock, sole clock of the block
rst  in  1  asynchronous, active-high reset
PS2_clk  in  1  raw PS/2 clock line
PS2_dat  in  1  raw PS/2 data line
out_data  out  DATA_BITS  received byte at the FIFO head
out_parity_err  out  1  head entry failed the parity check
out_frame_err  out  1  head entry had stop bit = 0
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts the head entry
overflow  out  1  sticky; a frame was dropped because the FIFO was full
timeout  out  1  one-cycle pulse when a partial frame is aborted
busy  out  1  high from start-bit acceptance until the frame ends or aborts

Behaviour:
- Reset (asynchronous, active-high): synchronisers and filter = 1; state IDLE; FIFO empty. All outputs are 0: out_data, both error flags, out_valid, overflow, timeout, busy.
- Filter: the filtered clock changes level only after the synchronised PS2_clk has differed from it for FILTER_LEN consecutive cycles. A falling edge of the filtered clock produces a 1-cycle fall strobe.
- Data is sampled from the synchronised PS2_dat on the fall strobe. No clock other than clk is used anywhere.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on the fall strobe, except timeout.
  - IDLE: sample 0 -> DATA, busy = 1, bit counter = 0. Sample 1 -> stay in IDLE (treated as noise).
  - DATA: shift the sample in LSB-first. After the DATA_BITS-th bit go to PARITY, or to STOP when PARITY_MODE = 2.
  - PARITY: parity error = (XOR of data bits XOR parity bit) != 1 for odd mode, != 0 for even mode. Go to STOP.
  - STOP: frame error = (sample == 0). Push {data, parity error, frame error} to the FIFO. Go to IDLE, busy = 0.
- Errored frames are still pushed; the consumer decides what to do with them.
- Timeout: a counter clears on every fall strobe and increments while not in IDLE. On reaching TIMEOUT_CYCLES: go to IDLE, discard the partial frame, pulse timeout for 1 cycle, busy = 0. Nothing is pushed.
- FIFO:
  - Push happens in the cycle after the stop-bit strobe; out_valid rises on the following cycle.
  - Pop occurs when out_valid && out_ready. out_data and the flags are stable while out_valid = 1 and no pop occurs.
  - Push and pop in the same cycle are both honoured at any occupancy, including full.
  - Push while full with no pop: the frame is dropped and overflow is set. FIFO contents are unchanged.
  - overflow clears only on rst.
- Pointers are log2(DEPTH)+1 bits wide. Full/empty are decided by the MSB comparison. Pointers wrap naturally.
- rst asserted mid-frame: the partial frame is lost and the block returns to IDLE immediately.

Decomposition:
- Package ps2_pkg holds:
  - FSM state enum (IDLE, DATA, PARITY, STOP)
  - PARITY_ODD / PARITY_EVEN / PARITY_NONE constants
  - a FIFO entry struct {data, parity_err, frame_err}
- One sub-module, ps2_sync_filter: synchroniser plus glitch filter plus fall-strobe generator, instantiated for PS2_clk (PS2_dat uses its synchroniser only).
- The FIFO stays inline in ps2_rx_fifo.

Test Plan:
- Frame 0x1C, odd parity bit 0, stop 1, out_ready = 1 -> out_valid pulses with out_data = 0x1C, both error flags 0, busy low after the stop bit.
- Frame 0x1C with parity bit 1 -> out_data = 0x1C, out_parity_err = 1. Stop bit 0 instead -> out_frame_err = 1. In PARITY_MODE = 2, a 10-bit frame is accepted with no parity check.
- Start bit plus 5 data bits, then the clock stops for TIMEOUT_CYCLES -> one timeout pulse, no push, FSM back in IDLE. The next frame 0xF0 is received correctly.
- DEPTH = 4, out_ready = 0, frames 0x01..0x05 -> overflow = 1. Popping then yields 0x01, 0x02, 0x03, 0x04 and out_valid = 0.
- PS2_clk low glitch of FILTER_LEN-1 cycles while in IDLE -> no fall strobe, busy stays 0, no state change.
- rst pulsed after the 4th data bit -> all outputs 0. The following full frame 0xAA is received with no errors.
